// File: rtl/aes_pkg.sv
// aes_pkg: definitions shared by the AES byte loader and its sub-module.
//   AES_BLOCK_BYTES : bytes per AES-128 block (16)
//   AES_BLOCK_W     : block width in bits (128)
//   state_t         : loader FSM state encoding (IDLE=0, START=1, WAIT=2, READY=3)
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W     = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    READY = 2'd3
  } state_t;

endpackage

// File: rtl/aes_byte_shreg.sv
// aes_byte_shreg: 128-bit byte shift-in register with a 4-bit byte count and
// a full flag. Bytes enter at the LSB end, so the first byte written ends up
// in [127:120].
//   clk, rst : clock, asynchronous active-low reset
//   clr      : clear count and full flag (contents are kept)
//   shift    : shift din in this cycle
//   din      : byte to shift in
//   value    : current register contents
//   full     : 16 bytes have been collected
module aes_byte_shreg
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   shift,
  input  logic [7:0]             din,
  output logic [AES_BLOCK_W-1:0] value,
  output logic                   full
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      cnt   <= '0;
      full  <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (shift) begin
      value <= {value[AES_BLOCK_W-9:0], din};
      if (full) begin
        // Writing into a full register starts a fresh fill; this byte is #1.
        cnt  <= 4'd1;
        full <= 1'b0;
      end else begin
        // The count wraps to 0 on the 16th byte; full marks completion.
        cnt <= cnt + 4'd1;
        if (cnt == 4'd15) full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_byte_loader.sv
// aes_byte_loader: byte-wide host front end for an AES-128 core. Collects 16
// plaintext and 16 key bytes (MSB first), pulses core_start, waits for
// core_done with a watchdog, then streams the 16 ciphertext bytes back.
//   clk, rst            : clock, asynchronous active-low reset
//   in_byte/in_is_key   : host write byte, 1 = key byte, 0 = plaintext byte
//   in_valid/in_ready   : host write handshake
//   out_byte            : ciphertext byte to the host
//   out_valid/out_ready : host read handshake
//   err                 : sticky timeout flag, cleared by the next plaintext byte
//   key_loaded          : 16 key bytes are held
//   core_data_in/core_key/core_start : to the AES core
//   core_data_out/core_done          : from the AES core
//   fsm_state           : current FSM state (debug)
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid/data may change only after such an edge or while ready
// is low; in_ready depends combinationally on in_is_key.
module aes_byte_loader
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_byte,
  input  logic                   in_is_key,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err,
  output logic                   key_loaded,
  output logic [AES_BLOCK_W-1:0] core_data_in,
  output logic [AES_BLOCK_W-1:0] core_key,
  output logic                   core_start,
  input  logic [AES_BLOCK_W-1:0] core_data_out,
  input  logic                   core_done,
  output logic [1:0]             fsm_state
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  state_t                 state;
  logic                   data_full;
  logic                   key_full;
  logic [AES_BLOCK_W-1:0] res_sr;
  logic [3:0]             out_cnt;
  logic [WD_W-1:0]        wdog;
  logic                   wr;
  logic                   timeout;
  logic                   last_out;
  logic                   data_clr;

  assign in_ready = (state == IDLE) && (in_is_key || !data_full);
  assign wr       = in_valid && in_ready;
  assign timeout  = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign last_out = out_valid && out_ready && (out_cnt == 4'd15);
  // Plaintext is discarded after a timeout and after a completed readout.
  assign data_clr = ((state == WAIT) && !core_done && timeout) ||
                    ((state == READY) && last_out);

  aes_byte_shreg u_data (
    .clk   (clk),
    .rst   (rst),
    .clr   (data_clr),
    .shift (wr && !in_is_key),
    .din   (in_byte),
    .value (core_data_in),
    .full  (data_full)
  );

  // The key is never cleared: it persists until a new fill or reset.
  aes_byte_shreg u_key (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .shift (wr && in_is_key),
    .din   (in_byte),
    .value (core_key),
    .full  (key_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      core_start <= 1'b0;
      err        <= 1'b0;
      res_sr     <= '0;
      out_cnt    <= '0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr && !in_is_key) err <= 1'b0;
          // Checked every cycle so the edge after the final byte of either
          // stream launches the transaction.
          if (data_full && key_full) begin
            state      <= START;
            core_start <= 1'b1;
          end
        end
        START: begin
          core_start <= 1'b0;
          wdog       <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          // done takes priority over a simultaneous timeout
          if (core_done) begin
            res_sr <= core_data_out;
            state  <= READY;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        READY: begin
          if (out_ready) begin
            res_sr <= {res_sr[AES_BLOCK_W-9:0], 8'h00};
            if (out_cnt == 4'd15) begin
              out_cnt <= '0;
              state   <= IDLE;
            end else begin
              out_cnt <= out_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid  = (state == READY);
  assign out_byte   = res_sr[AES_BLOCK_W-1 -: 8];
  assign key_loaded = key_full;
  assign fsm_state  = state;

endmodule

// File: tb/tb_aes_byte_loader.sv
// tb_aes_byte_loader: randomized bench for aes_byte_loader with a behavioural
// AES-128 core stub and a byte-level host model feeding an expected queue.
module tb_aes_byte_loader;

  logic         clk;
  logic         rst;
  logic [7:0]   in_byte;
  logic         in_is_key;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         err;
  logic         key_loaded;
  logic [127:0] core_data_in;
  logic [127:0] core_key;
  logic         core_start;
  logic [127:0] core_data_out;
  logic         core_done;
  logic [1:0]   fsm_state;

  aes_byte_loader #(.TIMEOUT_CYCLES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_byte       (in_byte),
    .in_is_key     (in_is_key),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_byte      (out_byte),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err           (err),
    .key_loaded    (key_loaded),
    .core_data_in  (core_data_in),
    .core_key      (core_key),
    .core_start    (core_start),
    .core_data_out (core_data_out),
    .core_done     (core_done),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_data[$];
  logic [7:0]  m_key[$];
  logic        hang;
  logic        use_known;
  logic        rand_ready;
  int          lat;
  logic [7:0]  sbox_t [256];
  logic [7:0]  mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- AES core stub ----------------
  logic         pend;
  int           pend_cnt;
  logic [127:0] pend_res;

  initial begin
    core_done     = 1'b0;
    core_data_out = '0;
    pend          = 1'b0;
    pend_cnt      = 0;
    pend_res      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        pend      = 1'b0;
        core_done = 1'b0;
      end else if (core_done) begin
        core_done     = 1'b0;
        core_data_out = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("valid_after_done", out_valid, 1);
      end else if (core_start && !hang) begin
        pend     = 1'b1;
        pend_cnt = lat;
        pend_res = aes_ref(core_data_in, core_key);
      end else if (pend) begin
        if (pend_cnt == 0) begin
          core_done     = 1'b1;
          core_data_out = pend_res;
          pend          = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  // ---------------- host read side ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL out_unexpected: got byte %0h with no byte expected", out_byte);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_byte", out_byte, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic k, input logic [7:0] b, output logic trig);
    logic         acc;
    logic [127:0] dblk;
    logic [127:0] kblk;
    logic [127:0] ct;
    acc  = 1'b0;
    trig = 1'b0;
    in_valid  = 1'b1;
    in_is_key = k;
    in_byte   = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      chk("write_accept", 0, 1);
    end else begin
      if (k) begin
        if (m_key.size() == 16) m_key.delete();
        m_key.push_back(b);
      end else begin
        m_data.push_back(b);
      end
      if (m_data.size() == 16 && m_key.size() == 16) begin
        trig = 1'b1;
        for (int i = 0; i < 16; i++) begin
          dblk[127-8*i -: 8] = m_data[i];
          kblk[127-8*i -: 8] = m_key[i];
        end
        ct = use_known ? 128'h3925841d02dc09fbdc118597196a0b32 : aes_ref(dblk, kblk);
        if (!hang)
          for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
        m_data.delete();
      end
    end
  endtask

  task automatic check_start(input string name);
    @(posedge clk); #1;
    chk({name, "_start_hi"}, core_start, 1);
    chk({name, "_state_start"}, fsm_state, 1);
    @(posedge clk); #1;
    chk({name, "_start_lo"}, core_start, 0);
    chk({name, "_state_wait"}, fsm_state, 2);
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && fsm_state == 2'd0) break;
    end
    chk({name, "_drain"}, (i < 3000), 1);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_in_ready"}, in_ready, 1);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_byte"}, out_byte, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_key_loaded"}, key_loaded, 0);
    chk({name, "_core_start"}, core_start, 0);
    chk({name, "_core_data_in"}, core_data_in, 0);
    chk({name, "_core_key"}, core_key, 0);
    chk({name, "_state"}, fsm_state, 0);
  endtask

  task automatic do_reset(input string name);
    #2 rst = 1'b0;
    #1 check_reset_vals(name);
    exp_q.delete();
    m_data.delete();
    m_key.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic write_data_block(input string name, input logic [127:0] blk, input logic expect_trig);
    logic trig;
    for (int i = 0; i < 16; i++) begin
      host_write(1'b0, blk[127-8*i -: 8], trig);
      if (i == 15) chk({name, "_trigger"}, trig, expect_trig);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] blk;
  logic         trig;
  int           cyc;
  int           nk;
  int           nd;
  logic         pick_key;

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_is_key  = 1'b0;
    in_byte    = 8'h00;
    hang       = 1'b0;
    use_known  = 1'b0;
    rand_ready = 1'b0;
    lat        = 2;
    build_sbox();

    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 vector: key first, then plaintext
    use_known = 1'b1;
    blk = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    for (int i = 0; i < 16; i++) host_write(1'b1, blk[127-8*i -: 8], trig);
    chk("fips_key_loaded", key_loaded, 1);
    write_data_block("fips", 128'h3243f6a8885a308d313198a2e0370734, 1'b1);
    check_start("fips");
    wait_drain("fips");
    use_known = 1'b0;

    // Key reuse: only 16 plaintext writes needed
    blk = 128'h00112233445566778899aabbccddeeff;
    for (int i = 0; i < 16; i++) begin
      host_write(1'b0, blk[127-8*i -: 8], trig);
      chk("reuse_key_loaded", key_loaded, 1);
      chk("reuse_trigger", trig, (i == 15));
    end
    check_start("reuse");
    chk("reuse_key_wait", key_loaded, 1);
    wait_drain("reuse");
    chk("reuse_key_after", key_loaded, 1);

    // Watchdog: core never completes
    hang = 1'b1;
    write_data_block("tmo", {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    check_start("tmo");
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (err) break;
    end
    chk("tmo_cycles", cyc, 64);
    chk("tmo_err", err, 1);
    chk("tmo_state", fsm_state, 0);
    chk("tmo_key_kept", key_loaded, 1);
    hang = 1'b0;
    host_write(1'b0, 8'($urandom_range(0, 255)), trig);
    chk("tmo_err_cleared", err, 0);
    for (int i = 0; i < 15; i++) host_write(1'b0, 8'($urandom_range(0, 255)), trig);
    chk("tmo_retry_trigger", trig, 1);
    check_start("tmo_retry");
    wait_drain("tmo_retry");

    // Asynchronous reset during WAIT
    lat = 40;
    write_data_block("rstw", {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    check_start("rstw");
    repeat (3) begin @(posedge clk); #1; end
    chk("rstw_in_wait", fsm_state, 2);
    do_reset("rst_wait");
    lat = 3;

    // 17th plaintext byte blocked while key is missing
    write_data_block("blk17", {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    in_valid  = 1'b1;
    in_is_key = 1'b0;
    in_byte   = 8'($urandom_range(0, 255));
    @(negedge clk);
    chk("blk17_ready_lo", in_ready, 0);
    @(posedge clk); #1;
    in_is_key = 1'b1;
    #1 chk("blk17_ready_key", in_ready, 1);
    for (int i = 0; i < 16; i++) host_write(1'b1, 8'($urandom_range(0, 255)), trig);
    chk("blk17_trigger", trig, 1);
    check_start("blk17");
    wait_drain("blk17");

    // Asynchronous reset mid-readout
    rand_ready = 1'b1;
    write_data_block("rstr", {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    check_start("rstr");
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (exp_q.size() <= 10) break;
    end
    chk("rstr_progress", (exp_q.size() <= 10), 1);
    chk("rstr_in_ready_state", fsm_state, 3);
    do_reset("rst_read");

    // Random transactions, random out_ready, random core latency
    for (int t = 0; t < 6; t++) begin
      lat = $urandom_range(0, 12);
      nk = 0;
      if (m_key.size() != 16 || $urandom_range(0, 1) == 1) begin
        // first key byte restarts (or starts) the key so old key cannot fire early
        host_write(1'b1, 8'($urandom_range(0, 255)), trig);
        nk = 15;
      end
      nd = 16;
      while (nk + nd > 0) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        pick_key = (nk > 0) && (nd == 0 || $urandom_range(0, 1) == 1);
        host_write(pick_key, 8'($urandom_range(0, 255)), trig);
        if (pick_key) nk--; else nd--;
      end
      chk("rand_trigger", trig, 1);
      check_start("rand");
      wait_drain("rand");
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
